// File: rtl/countgen_pkg.sv
// Shared definitions for the round-robin period-measurement scheduler.
package countgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } state_e;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_TIMEOUT     = 1000000;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/countgen_rr_pick.sv
// Combinational round-robin picker: first set mask bit strictly after 'last', wrapping.
module countgen_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   last,
    output logic [CH_W-1:0]   next,
    output logic              found
);

    always_comb begin
        next  = '0;
        found = 1'b0;
        // i runs to NUM_CH so the last-served channel itself is the final candidate
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!found && mask[(int'(last) + i) % NUM_CH]) begin
                found = 1'b1;
                next  = CH_W'((int'(last) + i) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/countgen_sched.sv
// Measures the period of one enabled input channel at a time, visiting channels
// round-robin with a single shared counter, and hands each result out over valid/ready.
module countgen_sched
    import countgen_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         in,
    input  logic [NUM_CH-1:0]         ch_enable,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NUM_CH)-1:0] out_chan,
    output logic [CNT_W-1:0]          out_period,
    output logic                      out_timeout,
    output logic                      busy,
    output logic [1:0]                state_dbg
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] ARM_LIMIT  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MEAS_LIMIT = CNT_W'(TIMEOUT);

    // Handshake: out_valid rises in REPORT and holds out_chan/out_period/out_timeout
    // steady; a transfer happens on any rising clk edge with out_valid && out_ready.
    // out_valid is decoded from the state register only, never from out_ready.

    state_e            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic [CH_W-1:0]   sel, sel_n, last, last_n, pick, chan_n;
    logic              hist, hist_n, rise, found;
    logic [CNT_W-1:0]  period_n;
    logic              timeout_n;
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] in_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign in_s = sync_q[SYNC_STAGES-1];

    countgen_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .mask  (ch_enable),
        .last  (last),
        .next  (pick),
        .found (found)
    );

    assign rise    = in_s[sel] & ~hist;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            sel         <= '0;
            last        <= CH_W'(NUM_CH - 1);
            hist        <= 1'b0;
            out_chan    <= '0;
            out_period  <= '0;
            out_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sel         <= sel_n;
            last        <= last_n;
            hist        <= hist_n;
            out_chan    <= chan_n;
            out_period  <= period_n;
            out_timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sel_n     = sel;
        last_n    = last;
        hist_n    = in_s[sel];
        chan_n    = out_chan;
        period_n  = out_period;
        timeout_n = out_timeout;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    sel_n   = pick;
                    hist_n  = in_s[pick];
                    cnt_n   = '0;
                    state_n = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!ch_enable[sel]) begin
                    state_n = ST_IDLE;
                end else if (rise) begin
                    cnt_n   = CNT_W'(1);
                    state_n = ST_MEASURE;
                end else if (cnt == ARM_LIMIT) begin
                    chan_n    = sel;
                    period_n  = '0;
                    timeout_n = 1'b1;
                    state_n   = ST_REPORT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_MEASURE: begin
                // edge is tested before the limit so a coincident edge still yields a period
                if (!ch_enable[sel]) begin
                    state_n = ST_IDLE;
                end else if (rise) begin
                    chan_n    = sel;
                    period_n  = cnt;
                    timeout_n = 1'b0;
                    state_n   = ST_REPORT;
                end else if (cnt == MEAS_LIMIT) begin
                    chan_n    = sel;
                    period_n  = '0;
                    timeout_n = 1'b1;
                    state_n   = ST_REPORT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_REPORT: begin
                if (out_ready) begin
                    last_n  = out_chan;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign out_valid = (state == ST_REPORT);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_countgen_sched.sv
// Bench for countgen_sched: table of measurement rounds plus hand-written corner sequences.
module tb_countgen_sched;
    import countgen_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int W      = 2 + 1 + CNT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] in_sig;
    logic [NUM_CH-1:0] ch_enable;
    logic              out_valid, out_ready, out_timeout, busy;
    logic [1:0]        out_chan, state_dbg;
    logic [CNT_W-1:0]  out_period;

    logic [NUM_CH-1:0] to_in, to_en;
    logic              to_valid, to_ready, to_timeout, to_busy;
    logic [1:0]        to_chan, to_state;
    logic [7:0]        to_period;

    int per_cfg [NUM_CH];
    int ph [NUM_CH];
    int to_per, to_ph;

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q [$];

    typedef struct {
        bit          do_rst;
        logic [3:0]  en;
        int          per [NUM_CH];
        logic [1:0]  chan;
        int          period;
        logic        tout;
    } vec_t;

    vec_t vecs [8];

    countgen_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT(1000), .SYNC_STAGES(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_sig),
        .ch_enable  (ch_enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_chan   (out_chan),
        .out_period (out_period),
        .out_timeout(out_timeout),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    countgen_sched #(.NUM_CH(NUM_CH), .CNT_W(8), .TIMEOUT(64), .SYNC_STAGES(3)) u_to (
        .clk        (clk),
        .rst        (rst),
        .in         (to_in),
        .ch_enable  (to_en),
        .out_valid  (to_valid),
        .out_ready  (to_ready),
        .out_chan   (to_chan),
        .out_period (to_period),
        .out_timeout(to_timeout),
        .busy       (to_busy),
        .state_dbg  (to_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // square-wave sources: low for the first half period after reset, edges P cycles apart
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int c = 0; c < NUM_CH; c++) begin
                if (rst || per_cfg[c] == 0) begin
                    ph[c] = 0;
                    in_sig[c] = 1'b0;
                end else begin
                    ph[c] = (ph[c] + 1) % per_cfg[c];
                    in_sig[c] = (ph[c] >= per_cfg[c] / 2);
                end
            end
            if (rst || to_per == 0) begin
                to_ph = 0;
                to_in = '0;
            end else begin
                to_ph = (to_ph + 1) % to_per;
                to_in = {1'b0, (to_ph >= to_per / 2), 2'b00};
            end
        end
    end

    // scoreboard: compare every accepted result with the head of exp_q
    initial begin
        logic [W-1:0] got, exp;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) begin
                got = {out_chan, out_timeout, out_period};
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got chan=%0d timeout=%0b period=%0d, required no result",
                             out_chan, out_timeout, out_period);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL result: got chan=%0d timeout=%0b period=%0d, required chan=%0d timeout=%0b period=%0d",
                                 got[W-1 -: 2], got[CNT_W], got[CNT_W-1:0],
                                 exp[W-1 -: 2], exp[CNT_W], exp[CNT_W-1:0]);
                    end
                end
            end
        end
    end

    // driver / check tasks
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic reset_with(input logic [3:0] en, input int p0, input int p1, input int p2, input int p3);
        @(negedge clk);
        rst = 1'b1;
        ch_enable = en;
        per_cfg[0] = p0;
        per_cfg[1] = p1;
        per_cfg[2] = p2;
        per_cfg[3] = p3;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] pack(input logic [1:0] chan, input logic tout, input int period);
        return {chan, tout, CNT_W'(period)};
    endfunction

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_measure(input int budget, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (state_dbg != ST_MEASURE && k < budget);
        chk(name, state_dbg, ST_MEASURE);
    endtask

    task automatic to_run(input string name, input int n_exp_arm, input int exp_period, input logic exp_tout);
        int n = 0;
        bit got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            #2;
            if (to_valid) got = 1;
            else if (to_busy) n++;
        end
        chk({name, "_valid"}, to_valid, 1);
        if (n_exp_arm >= 0) chk({name, "_arm_cycles"}, n, n_exp_arm);
        chk({name, "_chan"}, to_chan, 2);
        chk({name, "_period"}, to_period, exp_period);
        chk({name, "_timeout"}, to_timeout, exp_tout);
    endtask

    function automatic vec_t mk(input bit r, input logic [3:0] en, input int p0, input int p1,
                                input int p2, input int p3, input logic [1:0] chan, input int period);
        vec_t v;
        v.do_rst = r;
        v.en     = en;
        v.per[0] = p0;
        v.per[1] = p1;
        v.per[2] = p2;
        v.per[3] = p3;
        v.chan   = chan;
        v.period = period;
        v.tout   = 1'b0;
        return v;
    endfunction

    // main sequence
    initial begin
        rst = 1'b1;
        ch_enable = '0;
        out_ready = 1'b1;
        to_ready = 1'b0;
        to_en = 4'b0100;
        to_per = 0;
        for (int c = 0; c < NUM_CH; c++) per_cfg[c] = 0;

        vecs[0] = mk(1, 4'b0001, 100, 0, 0, 0, 2'd0, 100);
        vecs[1] = mk(0, 4'b0001, 100, 0, 0, 0, 2'd0, 100);
        vecs[2] = mk(0, 4'b0001, 100, 0, 0, 0, 2'd0, 100);
        vecs[3] = mk(1, 4'b1111, 20, 30, 40, 50, 2'd0, 20);
        vecs[4] = mk(0, 4'b1111, 20, 30, 40, 50, 2'd1, 30);
        vecs[5] = mk(0, 4'b1111, 20, 30, 40, 50, 2'd2, 40);
        vecs[6] = mk(0, 4'b1111, 20, 30, 40, 50, 2'd3, 50);
        vecs[7] = mk(0, 4'b1111, 20, 30, 40, 50, 2'd0, 20);

        repeat (4) @(negedge clk);
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_chan", out_chan, 0);
        chk("rst_period", out_period, 0);
        chk("rst_timeout", out_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state_dbg, ST_IDLE);
        chk("rst_to_busy", to_busy, 0);

        // channel 2 held low: ARM gives up after 64 cycles
        reset_with(4'b0000, 0, 0, 0, 0);
        to_run("to_flat", 64, 0, 1'b1);
        // period equal to the limit: coincident edge wins
        to_per = 64;
        reset_with(4'b0000, 0, 0, 0, 0);
        to_run("to_edge_at_limit", -1, 64, 1'b0);
        // one cycle beyond the limit times out in MEASURE
        to_per = 65;
        reset_with(4'b0000, 0, 0, 0, 0);
        to_run("to_over_limit", -1, 0, 1'b1);
        to_per = 0;

        // table: single-channel rounds, then four-channel round-robin
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_rst)
                reset_with(vecs[i].en, vecs[i].per[0], vecs[i].per[1], vecs[i].per[2], vecs[i].per[3]);
            exp_q.push_back(pack(vecs[i].chan, vecs[i].tout, vecs[i].period));
            wait_drain(400, $sformatf("vec%0d_drain", i));
        end

        // consumer stalls for 10 cycles while a result is held
        out_ready = 1'b0;
        reset_with(4'b0010, 0, 30, 0, 0);
        exp_q.push_back(pack(2'd1, 1'b0, 30));
        begin
            int k = 0;
            do begin
                @(negedge clk);
                #2;
                k++;
            end while (!out_valid && k < 200);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #2;
            chk("stall_valid", out_valid, 1);
            chk("stall_chan", out_chan, 1);
            chk("stall_period", out_period, 30);
            chk("stall_timeout", out_timeout, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        chk("stall_valid_after", out_valid, 0);
        chk("stall_popped", exp_q.size(), 0);
        exp_q.delete();

        // drop ch1 enable mid-measurement: abort, then ch2 is served
        out_ready = 1'b1;
        reset_with(4'b0110, 0, 30, 40, 0);
        wait_measure(100, "abort_reach_measure");
        ch_enable[1] = 1'b0;
        @(negedge clk);
        #2;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        exp_q.push_back(pack(2'd2, 1'b0, 40));
        wait_drain(400, "abort_next_drain");

        // reset mid-measurement discards the pending result and restarts at channel 0
        reset_with(4'b1111, 20, 30, 40, 50);
        exp_q.push_back(pack(2'd0, 1'b0, 20));
        wait_drain(400, "midrst_first_drain");
        wait_measure(100, "midrst_reach_measure");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_chan", out_chan, 0);
        chk("midrst_period", out_period, 0);
        chk("midrst_timeout", out_timeout, 0);
        chk("midrst_busy", busy, 0);
        exp_q.push_back(pack(2'd0, 1'b0, 20));
        wait_drain(400, "midrst_post_drain");
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/countgen_sched.md
COUNTGEN_SCHED -- requirements
Module: countgen_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of measured input channels (2..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of the period counter and result.
REQ-003 SHALL have parameter TIMEOUT, default 1000000, maximum cycles spent per measurement phase.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (>=2).
REQ-005 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in  input  NUM_CH  asynchronous periodic signals to measure.
REQ-008 SHALL have port ch_enable  input  NUM_CH  per-channel scheduling enable.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_chan  output  clog2(NUM_CH)  channel of result.
REQ-012 SHALL have port out_period  output  CNT_W  measured period in clk cycles.
REQ-013 SHALL have port out_timeout  output  1  measurement timed out.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-015 SHALL pass every in bit through a SYNC_STAGES flop synchronizer before use.
REQ-016 SHALL implement FSM states IDLE, ARM, MEASURE, REPORT; one shared CNT_W counter serves all channels.
REQ-017 IDLE: if any ch_enable bit set, SHALL select the next enabled channel strictly after the last-served channel (round-robin, wrapping NUM_CH-1 -> 0), load the edge-history flop with that channel's synchronized level, clear counter, go ARM; else stay.
REQ-018 Rising edge SHALL mean synchronized level 1 with history 0 on the selected channel only; history updates every cycle.
REQ-019 ARM: counter increments each cycle; on rising edge counter <= 1, go MEASURE; on counter == TIMEOUT-1 without edge, go REPORT with timeout=1, period=0.
REQ-020 MEASURE: counter increments each cycle; on rising edge capture period = counter, go REPORT with timeout=0; on counter == TIMEOUT without edge, go REPORT with timeout=1, period=0.
REQ-021 Period SHALL equal the clk-cycle distance between the two detected rising edges (edges P cycles apart -> out_period = P).
REQ-022 REPORT: out_valid=1 with out_chan/out_period/out_timeout stable until out_ready sampled high; then out_valid=0 next cycle, last-served <= out_chan, go IDLE.
REQ-023 If the selected channel's ch_enable drops in ARM or MEASURE, SHALL abort to IDLE next cycle with no report and no last-served update; REPORT is not aborted.
REQ-024 Edge and timeout in the same cycle: edge SHALL win.
REQ-025 Counter SHALL never wrap; TIMEOUT <= 2^CNT_W-1 is a legal-parameter requirement.
REQ-026 out_valid SHALL never depend combinationally on out_ready.

Reset
REQ-027 On rst: state IDLE, out_valid=0, out_chan=0, out_period=0, out_timeout=0, busy=0, counter=0, last-served=NUM_CH-1 (so channel 0 first), synchronizers and history cleared.
REQ-028 rst asserted mid-measurement or mid-REPORT SHALL discard the pending result.

Structure
REQ-029 State encoding enum and default parameter constants SHALL live in shared package countgen_pkg.
REQ-030 Round-robin next-channel selection SHALL be sub-module countgen_rr_pick (mask, last -> next, found), combinational.

Verification
REQ-031 Ch0 enabled only, square wave period 100 clk -> out_chan=0, out_period=100, out_timeout=0, repeated each round.
REQ-032 All 4 enabled, periods 20/30/40/50, out_ready tied 1 -> results in order chan 0,1,2,3,0 with matching periods.
REQ-033 Ch2 enabled, in[2] held 0, TIMEOUT=64 -> out_timeout=1, out_period=0, out_chan=2, after 64 ARM cycles.
REQ-034 out_ready held 0 for 10 cycles during REPORT -> out_valid and data stable 10 cycles, single transfer on ready.
REQ-035 ch_enable[1] cleared during MEASURE -> no result for ch1, busy=0 next cycle, next result from next enabled channel.
REQ-036 rst pulsed during MEASURE -> all outputs zero next cycle, first post-reset result is channel 0.
